// File: rtl/letreiro_paysandu_pkg.sv
// Character codes and message layout for the PAYSANDU marquee.
// The segment decoder imports this same package, so code assignments live in one place.
package letreiro_paysandu_pkg;

    localparam int MSG_LEN = 8;

    localparam logic [3:0] CHAR_P     = 4'd0;
    localparam logic [3:0] CHAR_A     = 4'd1;
    localparam logic [3:0] CHAR_Y     = 4'd2;
    localparam logic [3:0] CHAR_S     = 4'd3;
    localparam logic [3:0] CHAR_A2    = 4'd4;
    localparam logic [3:0] CHAR_N     = 4'd5;
    localparam logic [3:0] CHAR_D     = 4'd6;
    localparam logic [3:0] CHAR_U     = 4'd7;
    localparam logic [3:0] CHAR_VAZIO = 4'd8;

    // Stream symbol at index j: message first, blank padding after it.
    function automatic logic [3:0] char_code(input logic [5:0] j);
        logic [3:0] c;
        case (j)
            6'd0:    c = CHAR_P;
            6'd1:    c = CHAR_A;
            6'd2:    c = CHAR_Y;
            6'd3:    c = CHAR_S;
            6'd4:    c = CHAR_A2;
            6'd5:    c = CHAR_N;
            6'd6:    c = CHAR_D;
            6'd7:    c = CHAR_U;
            default: c = CHAR_VAZIO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/letreiro_paysandu_if.sv
// Control inputs and character/position outputs of the marquee sequencer.
interface letreiro_paysandu_if #(
    parameter int NUM_DIGITS = 6,
    parameter int PW         = $clog2(8 + NUM_DIGITS)
);
    logic                    habilita;
    logic                    direcao;
    logic                    passo;
    logic [4*NUM_DIGITS-1:0] caracteres;
    logic [PW-1:0]           posicao;
    logic                    volta;

    modport master (
        output habilita, direcao, passo,
        input  caracteres, posicao, volta
    );

    modport slave (
        input  habilita, direcao, passo,
        output caracteres, posicao, volta
    );
endinterface

// File: rtl/letreiro_paysandu_divisor_passo.sv
// Scroll prescaler: counts while enabled, holds while disabled, cleared by any step.
module divisor_passo #(
    parameter int STEP_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic habilita,
    input  logic limpa,
    output logic fim
);
    localparam int             CW = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] TC = CW'(STEP_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Terminal flag is combinational so the step lands on the STEP_TICKS-th edge.
    assign fim = habilita && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (limpa || fim)
            cnt_d = '0;
        else if (habilita)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/letreiro_paysandu.sv
// Marquee sequencer: scroll position, wrap detection and registered character window
// over "PAYSANDU" plus NUM_DIGITS blanks.
module letreiro_paysandu
    import letreiro_paysandu_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int STEP_TICKS = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    letreiro_paysandu_if.slave bus
);
    localparam int             L      = MSG_LEN + NUM_DIGITS;
    localparam int             PW     = $clog2(L);
    localparam logic [PW-1:0] P_LAST = PW'(L - 1);

    // HEX(NUM_DIGITS-1-k) shows stream[(p+k) mod L]; p+k < 2L so one subtraction wraps.
    function automatic logic [4*NUM_DIGITS-1:0] janela(input logic [PW-1:0] p);
        logic [4*NUM_DIGITS-1:0] w;
        logic [5:0]              j;
        w = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            j = 6'(p) + 6'(k);
            if (j >= 6'(L))
                j = j - 6'(L);
            w[4*(NUM_DIGITS-1-k) +: 4] = char_code(j);
        end
        return w;
    endfunction

    localparam logic [4*NUM_DIGITS-1:0] CAR_RST = janela('0);

    logic                    fim;
    logic                    passo_ev;
    logic [PW-1:0]           pos_q, pos_d;
    logic                    volta_q, volta_d;
    logic [4*NUM_DIGITS-1:0] car_q, car_d;

    divisor_passo #(
        .STEP_TICKS (STEP_TICKS)
    ) u_divisor (
        .clk      (clk),
        .rst_n    (rst_n),
        .habilita (bus.habilita),
        .limpa    (passo_ev),
        .fim      (fim)
    );

    // Manual and automatic steps coinciding collapse into a single step.
    assign passo_ev = bus.passo | fim;

    always_comb begin
        pos_d   = pos_q;
        volta_d = 1'b0;
        if (passo_ev) begin
            if (bus.direcao) begin
                if (pos_q == '0) begin
                    pos_d   = P_LAST;
                    volta_d = 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end else begin
                if (pos_q == P_LAST) begin
                    pos_d   = '0;
                    volta_d = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
        end
    end

    // Window taken from the next position so the characters track posicao on the same edge.
    always_comb begin
        car_d = janela(pos_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            volta_q <= 1'b0;
            car_q   <= CAR_RST;
        end else begin
            pos_q   <= pos_d;
            volta_q <= volta_d;
            car_q   <= car_d;
        end
    end

    assign bus.posicao    = pos_q;
    assign bus.volta      = volta_q;
    assign bus.caracteres = car_q;

endmodule

// File: tb/tb_letreiro_paysandu.sv
// Directed bench for the marquee sequencer with a per-cycle reference model.
module tb_letreiro_paysandu;
    localparam int ND = 6;
    localparam int ST = 4;
    localparam int L  = 8 + ND;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    letreiro_paysandu_if #(.NUM_DIGITS(ND)) bus ();

    letreiro_paysandu #(
        .NUM_DIGITS (ND),
        .STEP_TICKS (ST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int msg [8] = '{0, 1, 2, 3, 4, 5, 6, 7};

    int m_p   = 0;
    int m_cnt = 0;
    bit m_volta = 1'b0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] win(input int p);
        logic [23:0] w;
        int          j;
        int          code;
        w = '0;
        for (int k = 0; k < ND; k++) begin
            j    = (p + k) % L;
            code = (j < 8) ? msg[j] : 8;
            w[4*(ND-1-k) +: 4] = 4'(code);
        end
        return w;
    endfunction

    // Reference model of the scroll rules.
    wire m_stp = bus.passo || (bus.habilita && (m_cnt == ST - 1));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p     <= 0;
            m_cnt   <= 0;
            m_volta <= 1'b0;
        end else if (m_stp) begin
            m_cnt <= 0;
            if (bus.direcao) begin
                m_p     <= (m_p == 0) ? L - 1 : m_p - 1;
                m_volta <= (m_p == 0);
            end else begin
                m_p     <= (m_p + 1) % L;
                m_volta <= (m_p == L - 1);
            end
        end else begin
            m_volta <= 1'b0;
            if (bus.habilita) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pos",   32'(bus.posicao),    32'(m_p));
            chk("model_car",   32'(bus.caracteres), 32'(win(m_p)));
            chk("model_volta", 32'(bus.volta),      32'(m_volta));
        end
    end

    task automatic wait_pos(input int tgt, input int budget, input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (int'(bus.posicao) != tgt && n < budget);
        chk(nm, 32'(bus.posicao), 32'(tgt));
    endtask

    task automatic edges_to_pos1(input string nm);
        int edges = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (bus.posicao == 1) begin
                edges = n;
                break;
            end
        end
        chk(nm, 32'(edges), 32'd4);
    endtask

    initial begin
        bus.habilita = 1'b0;
        bus.direcao  = 1'b0;
        bus.passo    = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_car",   32'(bus.caracteres), 32'h012345);
        chk("rst_pos",   32'(bus.posicao),    32'd0);
        chk("rst_volta", 32'(bus.volta),      32'd0);
        cmp_en = 1'b1;

        // Automatic forward scroll from reset release.
        bus.habilita = 1'b1;
        rst_n        = 1'b1;
        edges_to_pos1("first_step_edge");
        chk("p1_car", 32'(bus.caracteres), 32'h123456);
        wait_pos(3, 20, "reach_p3");
        chk("p3_car", 32'(bus.caracteres), 32'h345678);
        wait_pos(8, 40, "reach_p8");
        chk("p8_car", 32'(bus.caracteres), 32'h888888);
        wait_pos(13, 40, "reach_p13");
        chk("p13_car", 32'(bus.caracteres), 32'h801234);
        wait_pos(0, 10, "wrap_p0");
        chk("wrap_volta", 32'(bus.volta), 32'd1);
        @(posedge clk); #1;
        chk("wrap_volta_clr", 32'(bus.volta), 32'd0);

        // Manual backward step from p = 0.
        @(negedge clk); #1;
        bus.habilita = 1'b0;
        bus.direcao  = 1'b1;
        bus.passo    = 1'b1;
        @(posedge clk); #1;
        chk("back_pos",   32'(bus.posicao),    32'd13);
        chk("back_car",   32'(bus.caracteres), 32'h801234);
        chk("back_volta", 32'(bus.volta),      32'd1);
        @(negedge clk); #1;
        bus.passo = 1'b0;
        @(posedge clk); #1;
        chk("back_volta_clr", 32'(bus.volta), 32'd0);

        // Enable dropped at count 2 holds the count; re-raise resumes from there.
        @(negedge clk); #1;
        bus.direcao  = 1'b0;
        bus.habilita = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        bus.habilita = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        bus.habilita = 1'b1;
        @(posedge clk); #1;
        chk("hold_no_early", 32'(bus.posicao), 32'd13);
        @(posedge clk); #1;
        chk("hold_step", 32'(bus.posicao), 32'd0);
        chk("hold_volta", 32'(bus.volta), 32'd1);

        // Manual step coinciding with terminal count: one step, prescaler restarts.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        bus.passo = 1'b1;
        @(posedge clk); #1;
        chk("coinc_pos", 32'(bus.posicao), 32'd1);
        @(negedge clk); #1;
        bus.passo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("coinc_restart_hold", 32'(bus.posicao), 32'd1);
        @(posedge clk); #1;
        chk("coinc_restart_step", 32'(bus.posicao), 32'd2);

        // Asynchronous reset between edges at p = 9.
        wait_pos(9, 40, "reach_p9");
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_car",   32'(bus.caracteres), 32'h012345);
        chk("arst_pos",   32'(bus.posicao),    32'd0);
        chk("arst_volta", 32'(bus.volta),      32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        edges_to_pos1("resume_step_edge");
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
